// File: rtl/chunked_borrow_subtractor_if.sv
// Handshake and data bundle for the chunked borrow subtractor.
// master: operand producer / result consumer. slave: the subtractor.
interface chunked_borrow_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bor;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bor, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bor, Ovf, Zero
  );
endinterface

// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle ripple-borrow subtractor: Diff = A - B - Bin, CHUNK bits per
// clock with the borrow carried in a register between slices. Results and
// flags are held in output registers until the next operation completes.
module chunked_borrow_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  chunked_borrow_subtractor_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             bor_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] diff_r;
  logic             bor_o;
  logic             ovf_o;
  logic             zero_o;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] work_nxt;
  logic             last;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Diff      = diff_r;
  assign bus.Bor       = bor_o;
  assign bus.Ovf       = ovf_o;
  assign bus.Zero      = zero_o;

  assign last = (idx == IW'(NCHUNK - 1));

  // One slice of the ripple-borrow subtraction, merged into the working result
  always_comb begin
    a_sl     = a_r[idx*CHUNK +: CHUNK];
    b_sl     = b_r[idx*CHUNK +: CHUNK];
    sub      = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, bor_r};
    work_nxt = work;
    work_nxt[idx*CHUNK +: CHUNK] = sub[CHUNK-1:0];
  end

  // Control FSM, operand capture, slice iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      bor_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      work   <= '0;
      diff_r <= '0;
      bor_o  <= 1'b0;
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            bor_r <= bus.Bin;
            work  <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_nxt;
          bor_r <= sub[CHUNK];
          if (last) begin
            // Flags are taken from the completed word so they load with Diff.
            diff_r <= work_nxt;
            bor_o  <= sub[CHUNK];
            ovf_o  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                      (work_nxt[WIDTH-1] != a_r[WIDTH-1]);
            zero_o <= (work_nxt == '0);
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/chunked_borrow_subtractor.md
Name: chunked_borrow_subtractor

Overview:
- Parametrised multi-cycle ripple-borrow subtractor. Computes Diff = A - B - Bin over WIDTH bits.
- Works CHUNK bits per clock, with the borrow held in a register between chunks.
- Trades latency for a short per-cycle borrow chain.
- Valid/ready handshakes on input and output; used as the subtract/compare engine beside the RV32I datapath.
- Adds borrow-out, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bor  output  1  borrow out of the MSB; 1 when unsigned A < B + Bin.
- Ovf  output  1  signed (two's-complement) overflow.
- Zero  output  1  Diff == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, chunk index=0, borrow register=0, operand/working registers=0.
  - Outputs: in_ready=1, out_valid=0, Diff=0, Bor=0, Ovf=0, Zero=0.
  - Reset during RUN or DONE discards the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture A, B; load borrow register with Bin; idx=0; go to RUN.
  - Later changes on A/B/Bin are ignored until the next accept.
- RUN:
  - in_ready=0.
  - Each cycle computes slice idx: {b_out, d} = A_slice - B_slice - borrow, as a (CHUNK+1)-bit subtraction.
  - d is written into the working-result slice idx; borrow <= b_out; idx <= idx+1.
  - On slice NCHUNK-1, the output registers load together:
    - Diff = working result with the final slice.
    - Bor = final b_out.
    - Ovf = (A[MSB] != B[MSB]) && (Diff[MSB] != A[MSB]); Bin takes no part in the overflow formula.
    - Zero = (Diff == 0).
  - Then state goes to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - Diff/Bor/Ovf/Zero stay stable while out_valid=1 and out_ready=0, for any length of backpressure.
  - On out_ready=1: out_valid drops next cycle and state goes to IDLE.
  - No new accept in the same cycle as the result handshake.
- Latency: accept at edge E0 → out_valid=1 after edge E0+NCHUNK. Throughput: one result per NCHUNK+2 cycles minimum.
- Between operations, the outputs hold the last completed result (out_valid=0 marks them stale). They are never updated mid-RUN.
- CHUNK==WIDTH: single RUN cycle; behaviour otherwise identical.
- idx wraps to 0 on entering DONE.
- out_ready while not in DONE: ignored.
- in_valid while not in IDLE: ignored; the operand is not consumed.

Test Plan:
- WIDTH=32, CHUNK=8: A=0x00000005, B=0x00000003, Bin=0 → Diff=0x00000002, Bor=0, Ovf=0, Zero=0; out_valid exactly 4 cycles after accept.
- A=0x00000000, B=0x00000001, Bin=0 → Diff=0xFFFFFFFF, Bor=1, Ovf=0, Zero=0. The borrow must ripple across all 4 chunks.
- A=0x80000000, B=0x00000001, Bin=0 → Diff=0x7FFFFFFF, Bor=0, Ovf=1. A=0x00000005, B=0x00000004, Bin=1 → Diff=0, Zero=1, Bor=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, toggling A/B/in_valid meanwhile → outputs unchanged, in_ready=0; then out_ready=1 → out_valid=0 and in_ready=1 on the next cycle.
- Async reset: pulse rst_n low during RUN idx=2 (asynchronously, mid-cycle) → outputs immediately read zero, state IDLE, in_ready=1. Then run A=0x12345678, B=0x02345678 → Diff=0x10000000, unaffected by the aborted operation.
- Re-run with CHUNK=1 and CHUNK=32: all of the above vectors give identical results, with latencies 32 and 1 respectively.
